soc_system_pio_step_gen: RTL and testbench



---
 rtl/soc_system_pio_pkg.sv | 23 ++
 rtl/soc_system_step_channel.sv | 100 ++++++++++
 rtl/soc_system_pio_step_gen.sv | 129 ++++++++++++
 tb/tb_soc_system_pio_step_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_pio_pkg
// Shared definitions for the step-generator PIO:
//   - word addresses of the Avalon-MM register map
//   - state encoding of the per-channel step FSM
// -----------------------------------------------------------------------------
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_OUTSET = 3'd1;
    localparam logic [2:0] ADDR_OUTCLR = 3'd2;
    localparam logic [2:0] ADDR_STEP   = 3'd3;
    localparam logic [2:0] ADDR_BURST  = 3'd4;
    localparam logic [2:0] ADDR_DONE   = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } ch_state_t;

endpackage

// File: rtl/soc_system_step_channel.sv
// -----------------------------------------------------------------------------
// soc_system_step_channel
// One step-pulse channel. A trigger while idle launches a burst of
// max(burst,1) pulses, each PULSE_LEN cycles high, separated by GAP_LEN
// cycles low. Triggers while busy are ignored.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   trig          launch request (sampled only in IDLE)
//   burst         pulse count, latched at launch
//   step          pulse output (decoded from the state register)
//   busy          channel not idle
//   done_pulse    high in the last cycle of the final pulse; the owner
//                 sets its sticky done flag on the following edge
// -----------------------------------------------------------------------------
module soc_system_step_channel
    import soc_system_pio_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic [CNT_W-1:0] burst,
    output logic             step,
    output logic             busy,
    output logic             done_pulse
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int PC_W    = $clog2(MAX_LEN) + 1;
    localparam logic [PC_W-1:0]  PULSE_LOAD = PC_W'(PULSE_LEN - 1);
    localparam logic [PC_W-1:0]  GAP_LOAD   = PC_W'(GAP_LEN - 1);
    localparam logic [PC_W-1:0]  PC_ONE     = PC_W'(1);
    localparam logic [CNT_W-1:0] REM_ONE    = CNT_W'(1);

    ch_state_t        state, state_nxt;
    // Single down-counter serves as pcnt in PULSE and gcnt in GAP.
    logic [PC_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        remaining_nxt = remaining;
        done_pulse    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nxt     = ST_PULSE;
                    cnt_nxt       = PULSE_LOAD;
                    // A stored burst of 0 still produces one pulse.
                    remaining_nxt = (burst == '0) ? REM_ONE : burst;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    if (remaining == REM_ONE) begin
                        state_nxt  = ST_IDLE;
                        done_pulse = 1'b1;
                    end else begin
                        state_nxt     = ST_GAP;
                        remaining_nxt = remaining - REM_ONE;
                        cnt_nxt       = GAP_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - PC_ONE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = PULSE_LOAD;
                end else begin
                    cnt_nxt = cnt - PC_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Derived straight from the state flop, so glitch-free and cleared
    // the instant reset_n falls.
    assign step = (state == ST_PULSE);
    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/soc_system_pio_step_gen.sv
// -----------------------------------------------------------------------------
// soc_system_pio_step_gen
// Avalon-MM slave PIO: a DATA_WIDTH-bit level output with atomic set/clear
// plus STEP_CH step-pulse channels with sticky done flags and a level irq.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   address        word address (0 DATA, 1 OUTSET, 2 OUTCLR, 3 STEP,
//                  4 BURST, 5 DONE, 6 IRQ_EN, 7 reserved)
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       read data, combinational from address
//   out_port       level outputs (data register)
//   step_port      step pulse outputs, one per channel
//   irq            registered |(done & irq_en)
// Bus protocol: a write is accepted on every clk edge where
// chipselect && !write_n (no wait states). Reads have zero latency:
// readdata follows address combinationally, regardless of chipselect.
// -----------------------------------------------------------------------------
module soc_system_pio_step_gen
    import soc_system_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int          STEP_CH     = 4,
    parameter int          PULSE_LEN   = 4,
    parameter int          GAP_LEN     = 4,
    parameter int          CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [STEP_CH-1:0]    step_port,
    output logic                  irq
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [CNT_W-1:0]      wd_burst;
    logic [STEP_CH-1:0]    wd_ch;

    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_W-1:0]      burst_reg;
    logic [STEP_CH-1:0]    done_reg;
    logic [STEP_CH-1:0]    irq_en_reg;
    logic                  irq_reg;

    logic [STEP_CH-1:0]    trig;
    logic [STEP_CH-1:0]    w1c;
    logic [STEP_CH-1:0]    busy;
    logic [STEP_CH-1:0]    done_pulse;

    // Upper writedata bits beyond each register width are intentionally dropped.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr_en    = chipselect && !write_n;
    assign wd_data  = writedata[DATA_WIDTH-1:0];
    assign wd_burst = writedata[CNT_W-1:0];
    assign wd_ch    = writedata[STEP_CH-1:0];

    assign trig = (wr_en && address == ADDR_STEP) ? wd_ch : '0;
    assign w1c  = (wr_en && address == ADDR_DONE) ? wd_ch : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg   <= DATA_WIDTH'(RESET_VALUE);
            burst_reg  <= CNT_W'(1);
            irq_en_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_reg   <= wd_data;
                ADDR_OUTSET: data_reg   <= data_reg | wd_data;
                ADDR_OUTCLR: data_reg   <= data_reg & ~wd_data;
                ADDR_BURST:  burst_reg  <= wd_burst;
                ADDR_IRQ_EN: irq_en_reg <= wd_ch;
                default: ;
            endcase
        end
    end

    // Completion has priority over a coincident write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            done_reg <= (done_reg & ~w1c) | done_pulse;
            irq_reg  <= |(done_reg & irq_en_reg);
        end
    end

    for (genvar ch = 0; ch < STEP_CH; ch++) begin : g_ch
        soc_system_step_channel #(
            .PULSE_LEN (PULSE_LEN),
            .GAP_LEN   (GAP_LEN),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .trig       (trig[ch]),
            .burst      (burst_reg),
            .step       (step_port[ch]),
            .busy       (busy[ch]),
            .done_pulse (done_pulse[ch])
        );
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[DATA_WIDTH-1:0] = data_reg;
            ADDR_STEP:   readdata[STEP_CH-1:0]    = busy;
            ADDR_BURST:  readdata[CNT_W-1:0]      = burst_reg;
            ADDR_DONE:   readdata[STEP_CH-1:0]    = done_reg;
            ADDR_IRQ_EN: readdata[STEP_CH-1:0]    = irq_en_reg;
            default:     readdata = '0;
        endcase
    end

    assign out_port = data_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_soc_system_pio_step_gen.sv
module tb_soc_system_pio_step_gen;
    import soc_system_pio_pkg::*;

    localparam int DW   = 8;
    localparam int NCH  = 4;
    localparam int PL   = 4;
    localparam int GL   = 4;
    localparam int CW   = 16;
    localparam int PER  = PL + GL;

    // ---------------- clock / reset ----------------
    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [2:0]    address    = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = '0;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic [NCH-1:0] step_port;
    logic          irq;

    always #5 clk = ~clk;

    soc_system_pio_step_gen #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (0),
        .STEP_CH     (NCH),
        .PULSE_LEN   (PL),
        .GAP_LEN     (GL),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .step_port  (step_port),
        .irq        (irq)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by its launch edge and burst length; busy,
    // step and completion follow from the window arithmetic below.
    int          cyc = 0;
    logic [DW-1:0]  m_data   = '0;
    logic [CW-1:0]  m_burst  = CW'(1);
    logic [NCH-1:0] m_done   = '0;
    logic [NCH-1:0] m_irq_en = '0;
    logic           m_irq    = 1'b0;
    int  launch[NCH];
    int  blen[NCH];
    bit  act[NCH];

    function automatic int win(input int n);
        return n * PL + (n - 1) * GL;
    endfunction

    function automatic bit m_busy(input int ch, input int k);
        return act[ch] && (k >= launch[ch]) && (k < launch[ch] + win(blen[ch]));
    endfunction

    function automatic bit m_step(input int ch, input int k);
        return m_busy(ch, k) && (((k - launch[ch]) % PER) < PL);
    endfunction

    function automatic logic [NCH-1:0] busy_mask(input int k);
        logic [NCH-1:0] r;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) r[ch] = m_busy(ch, k);
        return r;
    endfunction

    function automatic logic [NCH-1:0] step_mask(input int k);
        logic [NCH-1:0] r;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) r[ch] = m_step(ch, k);
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            ADDR_DATA:   r = 32'(m_data);
            ADDR_STEP:   r = 32'(busy_mask(cyc));
            ADDR_BURST:  r = 32'(m_burst);
            ADDR_DONE:   r = 32'(m_done);
            ADDR_IRQ_EN: r = 32'(m_irq_en);
            default:     r = '0;
        endcase
        return r;
    endfunction

    // Model advances on every active edge; cycle k is the interval after edge k.
    always @(posedge clk or negedge reset_n) begin
        int e;
        logic [NCH-1:0] fin;
        logic [NCH-1:0] clr;
        if (!reset_n) begin
            m_data   = '0;
            m_burst  = CW'(1);
            m_done   = '0;
            m_irq_en = '0;
            m_irq    = 1'b0;
            for (int ch = 0; ch < NCH; ch++) act[ch] = 1'b0;
        end else begin
            e   = cyc + 1;
            fin = '0;
            clr = '0;
            for (int ch = 0; ch < NCH; ch++)
                if (act[ch] && (launch[ch] + win(blen[ch]) == e)) fin[ch] = 1'b1;
            m_irq = |(m_done & m_irq_en);
            if (chipselect && !write_n) begin
                case (address)
                    ADDR_DATA:   m_data = writedata[DW-1:0];
                    ADDR_OUTSET: m_data = m_data | writedata[DW-1:0];
                    ADDR_OUTCLR: m_data = m_data & ~writedata[DW-1:0];
                    ADDR_BURST:  m_burst = writedata[CW-1:0];
                    ADDR_IRQ_EN: m_irq_en = writedata[NCH-1:0];
                    ADDR_DONE:   clr = writedata[NCH-1:0];
                    ADDR_STEP: begin
                        for (int ch = 0; ch < NCH; ch++) begin
                            if (writedata[ch] && !m_busy(ch, e - 1)) begin
                                act[ch]    = 1'b1;
                                launch[ch] = e;
                                blen[ch]   = (m_burst == '0) ? 1 : int'(m_burst);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            m_done = (m_done & ~clr) | fin;
            cyc    = e;
        end
    end

    // Continuous output comparison, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("out_port", 32'(out_port), 32'(m_data));
            check("step_port", 32'(step_port), 32'(step_mask(cyc)));
            check("irq", 32'(irq), 32'(m_irq));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after an active edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, output logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        exp_q.push_back(m_read(a));
        v = readdata;
        check(tag, readdata, exp_q.pop_front());
        @(posedge clk);
        #1;
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] v;
    logic [31:0] reset_exp[8];

    initial begin
        reset_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0};

        // reset state
        #12;
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_step_port", 32'(step_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), "rst_read", v);
            check("rst_read_const", v, reset_exp[a]);
        end

        // level output with set/clear
        wr(ADDR_DATA, 32'h0000_00A5);
        check("data_a5", 32'(out_port), 32'hA5);
        wr(ADDR_OUTSET, 32'h0000_000A);
        check("outset_af", 32'(out_port), 32'hAF);
        wr(ADDR_OUTCLR, 32'h0000_0081);
        check("outclr_2e", 32'(out_port), 32'h2E);
        rd(ADDR_DATA, "rd_data", v);
        check("rd_data_const", v, 32'h2E);
        rd(ADDR_OUTSET, "rd_outset", v);
        rd(ADDR_OUTCLR, "rd_outclr", v);

        // burst of 3 on channel 0
        wr(ADDR_BURST, 32'd3);
        wr(ADDR_STEP, 32'h1);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("b3_step0", 32'(step_port[0]), 32'((i < 20) && ((i % 8) < 4)));
        end
        @(posedge clk);
        #1;
        rd(ADDR_DONE, "b3_done", v);
        check("b3_done_const", v, 32'h1);

        // lockstep pair, ignored retrigger and mid-burst BURST change
        wr(ADDR_DONE, 32'hF);
        wr(ADDR_BURST, 32'd2);
        wr(ADDR_STEP, 32'h3);
        idle(4);
        wr(ADDR_STEP, 32'h1);
        wr(ADDR_BURST, 32'd7);
        rd(ADDR_STEP, "pair_busy", v);
        check("pair_busy_const", v, 32'h3);
        idle(20);
        rd(ADDR_DONE, "pair_done", v);
        check("pair_done_const", v, 32'h3);
        rd(ADDR_BURST, "pair_burst", v);

        // irq path and W1C priority
        wr(ADDR_DONE, 32'hF);
        wr(ADDR_IRQ_EN, 32'h2);
        wr(ADDR_BURST, 32'd1);
        wr(ADDR_STEP, 32'h2);
        idle(4);
        check("irq_lag", 32'(irq), 32'h0);
        idle(1);
        check("irq_set", 32'(irq), 32'h1);
        wr(ADDR_DONE, 32'h2);
        idle(1);
        check("irq_clr", 32'(irq), 32'h0);
        wr(ADDR_STEP, 32'h2);
        idle(3);
        wr(ADDR_DONE, 32'h2);
        rd(ADDR_DONE, "w1c_vs_set", v);
        check("w1c_vs_set_const", 32'(v[1]), 32'h1);

        // burst value 0 behaves as a single pulse
        wr(ADDR_BURST, 32'd0);
        wr(ADDR_STEP, 32'h4);
        idle(6);
        rd(ADDR_BURST, "burst0", v);
        rd(ADDR_DONE, "burst0_done", v);
        check("burst0_done_const", 32'(v[2]), 32'h1);

        // reset during a pulse
        wr(ADDR_DONE, 32'hF);
        wr(ADDR_BURST, 32'd3);
        wr(ADDR_STEP, 32'h1);
        idle(8);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_step", 32'(step_port), 32'h0);
        address = ADDR_STEP;
        #1;
        check("async_rst_busy", readdata, 32'h0);
        address = ADDR_DONE;
        #1;
        check("async_rst_done", readdata, 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        #20;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wr(ADDR_STEP, 32'h1);
        idle(6);
        rd(ADDR_DONE, "post_rst_done", v);
        check("post_rst_done_const", v, 32'h1);

        // randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0: wr(ADDR_DATA, $urandom);
                1: wr(3'($urandom_range(1, 2)), $urandom);
                2, 3: wr(ADDR_STEP, $urandom);
                4: wr(ADDR_BURST, 32'($urandom_range(0, 3)));
                5: wr(ADDR_DONE, $urandom);
                6: wr(ADDR_IRQ_EN, $urandom);
                7: rd(3'($urandom_range(0, 7)), "rand_rd", v);
                8: wr(3'd7, $urandom);
                default: idle(int'($urandom_range(1, 6)));
            endcase
        end
        idle(40);
        for (int a = 0; a < 8; a++) rd(3'(a), "final_rd", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
